// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, ALU control codes, ALUOp
// encodings, the ID/EX payload record and the forwarding match helper.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // ALU control codes understood by the ALU
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // ALUOp encodings produced by the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  // Everything the stage holds for one instruction
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [3:0]      control;
    logic            illegal;
    logic            alu_src;
    logic            reg_write;
  } idex_payload_t;

  // Write-back hits a source operand; x0 is hardwired and never matches
  function automatic logic fwd_hit(input logic            we,
                                   input logic [REGW-1:0] wb_rd,
                                   input logic [REGW-1:0] rs);
    return we && (wb_rd != '0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, write-back and ALU-side signals of the ID/EX stage.
// slave = the stage itself, master = its environment.
interface id_ex_stage_if;
  import riscv_pkg::*;

  // decode side
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [REGW-1:0] in_rs1;
  logic [REGW-1:0] in_rs2;
  logic [REGW-1:0] in_rd;
  logic [1:0]      in_alu_op;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic            in_is_rtype;
  logic            in_alu_src;
  logic            in_reg_write;
  // write-back port
  logic            fwd_we;
  logic [REGW-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            flush;
  // ALU side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rd1;
  logic [XLEN-1:0] out_rd2_or_imm;
  logic [3:0]      out_control;
  logic [XLEN-1:0] out_store_data;
  logic [REGW-1:0] out_rd;
  logic            out_reg_write;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_alu_op, in_funct3, in_funct7b5,
           in_is_rtype, in_alu_src, in_reg_write,
           fwd_we, fwd_rd, fwd_data, flush, out_ready,
    output in_ready, out_valid, out_rd1, out_rd2_or_imm, out_control,
           out_store_data, out_rd, out_reg_write, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_alu_op, in_funct3, in_funct7b5,
           in_is_rtype, in_alu_src, in_reg_write,
           fwd_we, fwd_rd, fwd_data, flush, out_ready,
    input  in_ready, out_valid, out_rd1, out_rd2_or_imm, out_control,
           out_store_data, out_rd, out_reg_write, out_pc, out_illegal
  );

endinterface

// File: rtl/alu_control_decode.sv
// ALUOp/funct3/funct7 to 4-bit ALU control. Purely combinational so later
// stages can reuse it.
module alu_control_decode
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output logic [3:0] control_o,
  output logic       illegal_o
);

  // funct7b5 only means SUB for register-register ops; ADDI ignores it
  always_comb begin
    control_o = ALU_ILLEGAL;
    case (alu_op_i)
      ALUOP_MEM:    control_o = ALU_ADD;
      ALUOP_BRANCH: control_o = ALU_SUB;
      ALUOP_ARITH: begin
        case (funct3_i)
          3'b000:  control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  control_o = ALU_AND;
          3'b110:  control_o = ALU_OR;
          default: control_o = ALU_ILLEGAL;
        endcase
      end
      default:      control_o = ALU_ILLEGAL;
    endcase
  end

  assign illegal_o = (control_o == ALU_ILLEGAL);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: valid/ready capture of decoded fields, ALU
// control generation, write-back forwarding at capture and while stalled,
// and operand-B selection from registered state.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  idex_payload_t pl_q, pl_d;
  logic [3:0]    dec_ctrl;
  logic          dec_illegal;
  logic          xfer;
  logic          stalled;

  alu_control_decode u_dec (
    .alu_op_i   (bus.in_alu_op),
    .funct3_i   (bus.in_funct3),
    .funct7b5_i (bus.in_funct7b5),
    .is_rtype_i (bus.in_is_rtype),
    .control_o  (dec_ctrl),
    .illegal_o  (dec_illegal)
  );

  assign bus.in_ready = (state_q == ST_EMPTY) | bus.out_ready;
  assign xfer         = bus.in_valid & bus.in_ready;
  assign stalled      = (state_q == ST_FULL) & ~bus.out_ready;

  // Next state; flush wins and also swallows a same-cycle transfer
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = xfer ? ST_FULL : ST_EMPTY;
        ST_FULL:  if (bus.out_ready) state_d = xfer ? ST_FULL : ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Payload: load on transfer (forwarding the new sources), otherwise
  // patch held sources from write-back while stalled
  always_comb begin
    pl_d = pl_q;
    if (xfer) begin
      pl_d.pc        = bus.in_pc;
      pl_d.rs1_data  = fwd_hit(bus.fwd_we, bus.fwd_rd, bus.in_rs1) ?
                       bus.fwd_data : bus.in_rs1_data;
      pl_d.rs2_data  = fwd_hit(bus.fwd_we, bus.fwd_rd, bus.in_rs2) ?
                       bus.fwd_data : bus.in_rs2_data;
      pl_d.imm       = bus.in_imm;
      pl_d.rs1       = bus.in_rs1;
      pl_d.rs2       = bus.in_rs2;
      pl_d.rd        = bus.in_rd;
      pl_d.control   = dec_ctrl;
      pl_d.illegal   = dec_illegal;
      pl_d.alu_src   = bus.in_alu_src;
      pl_d.reg_write = bus.in_reg_write;
    end else if (stalled) begin
      if (fwd_hit(bus.fwd_we, bus.fwd_rd, pl_q.rs1)) pl_d.rs1_data = bus.fwd_data;
      if (fwd_hit(bus.fwd_we, bus.fwd_rd, pl_q.rs2)) pl_d.rs2_data = bus.fwd_data;
    end
  end

  // State and payload registers; reset clears everything to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
    end
  end

  assign bus.out_valid      = (state_q == ST_FULL);
  assign bus.out_rd1        = pl_q.rs1_data;
  assign bus.out_rd2_or_imm = pl_q.alu_src ? pl_q.imm : pl_q.rs2_data;
  assign bus.out_store_data = pl_q.rs2_data;
  assign bus.out_control    = pl_q.control;
  assign bus.out_illegal    = pl_q.illegal;
  assign bus.out_rd         = pl_q.rd;
  assign bus.out_reg_write  = pl_q.reg_write;
  assign bus.out_pc         = pl_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed test of id_ex_stage: decode codes, operand select, forwarding,
// stall, flush, illegal decode and asynchronous reset.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] rs1d, input logic [4:0] rs2,
                        input logic [31:0] rs2d, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [1:0] op,
                        input logic [2:0] f3, input logic f7,
                        input logic rt, input logic src);
    bus.in_pc        = pc;
    bus.in_rs1       = rs1;
    bus.in_rs1_data  = rs1d;
    bus.in_rs2       = rs2;
    bus.in_rs2_data  = rs2d;
    bus.in_rd        = rd;
    bus.in_imm       = imm;
    bus.in_alu_op    = op;
    bus.in_funct3    = f3;
    bus.in_funct7b5  = f7;
    bus.in_is_rtype  = rt;
    bus.in_alu_src   = src;
    bus.in_reg_write = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush = 1'b0;
    bus.fwd_we = 1'b0;
    bus.fwd_rd = '0;
    bus.fwd_data = '0;
    set_in(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    bus.in_reg_write = 1'b0;

    // reset state
    #2;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_control", 32'(bus.out_control), 32'h0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_rd1", bus.out_rd1, 32'h0);
    #5 rst_n = 1'b1;
    tick();

    // 1: ADD
    set_in(32'h100, 5'd1, 32'd10, 5'd2, 32'd5, 5'd5, 32'h0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_control", 32'(bus.out_control), 32'h2);
    chk("add_rd1", bus.out_rd1, 32'd10);
    chk("add_opb", bus.out_rd2_or_imm, 32'd5);
    chk("add_rd", 32'(bus.out_rd), 32'd5);
    chk("add_pc", bus.out_pc, 32'h100);
    chk("add_regw", 32'(bus.out_reg_write), 32'd1);

    // 2: SUB, then ADDI with immediate operand
    bus.in_funct7b5 = 1'b1;
    tick();
    chk("sub_control", 32'(bus.out_control), 32'h6);
    chk("sub_illegal", 32'(bus.out_illegal), 32'd0);
    bus.in_is_rtype = 1'b0;
    bus.in_alu_src  = 1'b1;
    bus.in_imm      = 32'hFFFF_FFFC;
    tick();
    chk("addi_control", 32'(bus.out_control), 32'h2);
    chk("addi_opb", bus.out_rd2_or_imm, 32'hFFFF_FFFC);
    chk("addi_store", bus.out_store_data, 32'd5);
    bus.in_alu_src = 1'b0;
    bus.in_funct3 = 3'b111;
    tick();
    chk("and_control", 32'(bus.out_control), 32'h0);
    bus.in_funct3 = 3'b110;
    tick();
    chk("or_control", 32'(bus.out_control), 32'h1);
    bus.in_alu_op = 2'b00;
    tick();
    chk("mem_control", 32'(bus.out_control), 32'h2);
    bus.in_alu_op = 2'b01;
    tick();
    chk("br_control", 32'(bus.out_control), 32'h6);

    // 3: forwarding at capture, x0 exclusion, independent rs2 match
    set_in(32'h200, 5'd3, 32'd7, 5'd4, 32'd8, 5'd6, 32'h0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    bus.fwd_we = 1'b1;
    bus.fwd_rd = 5'd3;
    bus.fwd_data = 32'd99;
    tick();
    chk("fwd_rs1", bus.out_rd1, 32'd99);
    chk("fwd_rs1_store", bus.out_store_data, 32'd8);
    bus.in_rs1 = 5'd0;
    bus.fwd_rd = 5'd0;
    tick();
    chk("fwd_x0", bus.out_rd1, 32'd7);
    bus.in_rs1 = 5'd3;
    bus.fwd_rd = 5'd4;
    tick();
    chk("fwd_rs2_rd1", bus.out_rd1, 32'd7);
    chk("fwd_rs2_store", bus.out_store_data, 32'd99);
    chk("fwd_rs2_opb", bus.out_rd2_or_imm, 32'd99);
    bus.fwd_we = 1'b0;

    // 4: stall with forwarding while held
    set_in(32'h300, 5'd6, 32'h11, 5'd7, 32'h22, 5'd8, 32'h0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    set_in(32'h400, 5'd9, 32'hDEAD, 5'd10, 32'hBEEF, 5'd11, 32'h0, 2'b10, 3'b111, 1'b0, 1'b1, 1'b0);
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_rd1", bus.out_rd1, 32'h11);
      chk("stall_pc", bus.out_pc, 32'h300);
    end
    bus.fwd_we = 1'b1;
    bus.fwd_rd = 5'd7;
    bus.fwd_data = 32'h77;
    tick();
    chk("held_fwd_store", bus.out_store_data, 32'h77);
    chk("held_fwd_opb", bus.out_rd2_or_imm, 32'h77);
    chk("held_fwd_rd1", bus.out_rd1, 32'h11);
    bus.fwd_we = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("refill_pc", bus.out_pc, 32'h400);
    chk("refill_control", 32'(bus.out_control), 32'h0);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // 5: flush kills held instruction and current input
    set_in(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    chk("pre_flush_valid", 32'(bus.out_valid), 32'd1);
    bus.in_pc = 32'h504;
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("flush_no_present", 32'(bus.out_valid), 32'd0);

    // 6: illegal decode, then reset mid-stall
    set_in(32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 2'b11, 3'b000, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    chk("ill_op_control", 32'(bus.out_control), 32'hF);
    chk("ill_op_flag", 32'(bus.out_illegal), 32'd1);
    bus.in_alu_op = 2'b10;
    bus.in_funct3 = 3'b001;
    tick();
    chk("ill_f3_control", 32'(bus.out_control), 32'hF);
    chk("ill_f3_flag", 32'(bus.out_illegal), 32'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_control", 32'(bus.out_control), 32'h0);
    chk("mid_rst_illegal", 32'(bus.out_illegal), 32'd0);
    chk("mid_rst_pc", bus.out_pc, 32'h0);
    chk("mid_rst_store", bus.out_store_data, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand/control generator between instruction decode and the ALU in the RISC-V core. Captures decoded fields with a valid/ready handshake and derives the 4-bit ALU control code from ALUOp/funct3/funct7. Resolves a write-back forwarding hazard at capture and while stalled. Drives the ALU's `Rd1`, `Rd2_or_Imm` and `control_in` directly from registered state.

## Interface
- No parameters; data width is fixed at 32 and register index width at 5.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1: decode-side handshake.
- `in_pc` in 32: instruction PC.
- `in_rs1_data`, `in_rs2_data` in 32 each: register-file read data.
- `in_imm` in 32: sign-extended immediate.
- `in_rs1`, `in_rs2`, `in_rd` in 5 each: register indices.
- `in_alu_op` in 2: 00 = load/store, 01 = branch, 10 = R/I arithmetic, 11 = reserved.
- `in_funct3` in 3, `in_funct7b5` in 1, `in_is_rtype` in 1: decode fields.
- `in_alu_src` in 1: 1 selects the immediate as ALU operand B.
- `in_reg_write` in 1: instruction writes `rd`.
- `fwd_we` in 1, `fwd_rd` in 5, `fwd_data` in 32: write-back port.
- `flush` in 1: kill the held instruction and the current input.
- `out_valid` out 1, `out_ready` in 1: ALU-side handshake.
- `out_rd1` out 32: ALU operand A.
- `out_rd2_or_imm` out 32: ALU operand B.
- `out_control` out 4: ALU control code.
- `out_store_data` out 32: rs2 data, forwarded if matched.
- `out_rd` out 5, `out_reg_write` out 1, `out_pc` out 32: passed through to the next stage.
- `out_illegal` out 1: the ALU control decode hit the illegal case.

## Operation
- **ALU control codes**: AND = 0000, OR = 0001, ADD = 0010, SUB = 0110, ILLEGAL = 1111. The ALU produces 0 for ILLEGAL.
- **ALU control decode**, evaluated on input fields at capture:
  - ALUOp 00 → ADD.
  - ALUOp 01 → SUB.
  - ALUOp 10:
    - funct3 000 → SUB if `in_is_rtype` and funct7b5 are both 1, else ADD.
    - funct3 111 → AND.
    - funct3 110 → OR.
    - any other funct3 → ILLEGAL.
  - ALUOp 11 → ILLEGAL.
  - `out_illegal` = 1 exactly when the stored code is 1111.
- **Forwarding at capture**: if `fwd_we`, `fwd_rd` ≠ 0 and `fwd_rd` == `in_rs1`, store `fwd_data` as rs1 data. The same rule applies independently to rs2.
- **Forwarding while held**: when `out_valid` is 1 and `out_ready` is 0, a matching write-back overwrites the stored rs1/rs2 data. The stored rs1/rs2 indices are retained for this comparison.
- **Operand B** is combinational from registered state: `out_rd2_or_imm` = stored `alu_src` ? stored imm : stored rs2 data. `out_store_data` is the stored rs2 data.
- **States**: EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
- **Handshake**: `in_ready` = !`out_valid` | `out_ready`, purely combinational. A transfer occurs when `in_valid` & `in_ready`.
- **Transitions without flush**:
  - EMPTY + transfer → FULL, loading the input.
  - FULL + `out_ready` + transfer → FULL, loading the new input.
  - FULL + `out_ready` + no transfer → EMPTY.
  - FULL + !`out_ready` → hold all stored state except the forwarding updates.
- **Flush**: has priority over everything. On the next edge `out_valid` = 0. An input transferred in the same cycle is consumed and discarded. Payload registers may load but are don't-care.
- Index x0 never matches for forwarding.

## Timing
- Latency is one cycle from an input transfer to `out_valid`. Full throughput is one instruction per cycle when `out_ready` stays 1.
- `out_rd2_or_imm` and `out_illegal` are combinational from registers only. There is no input-to-output combinational path other than `out_ready` → `in_ready`.
- **Reset** (async assert, sync deassert handled externally):
  - `out_valid` = 0.
  - All payload outputs = 0, so `out_control` = 0000 (AND) and `out_illegal` = 0.
  - `in_ready` = 1.
- Reset mid-stall drops the held instruction with no output transfer.
- A write-back in the same cycle as capture uses `fwd_data`, not the register-file read value.
- A write-back on the same edge as a FULL→FULL replacement applies to the new instruction only.

## Structure
- **Shared package `riscv_pkg`**:
  - ALU control localparams: AND, OR, ADD, SUB, ILLEGAL.
  - ALUOp encodings.
  - Width constants XLEN = 32 and REGW = 5.
- **Sub-module `alu_control_decode`**: combinational decode of alu_op/funct3/funct7b5/is_rtype into control and illegal. It is shared with future stages.
- **Top level**: state register, payload registers, forwarding compare and operand-B mux.

## Test plan
1. **ADD**: rs1 data = 10, rs2 data = 5, ALUOp 10, funct3 000, R-type, funct7b5 = 0, `out_ready` = 1 → next cycle `out_valid` = 1, `out_control` = 0010, `out_rd1` = 10, `out_rd2_or_imm` = 5.
2. **SUB and immediate select**: ALUOp 10, funct3 000, R-type, funct7b5 = 1 → `out_control` = 0110. Same fields with `in_is_rtype` = 0, `in_alu_src` = 1, imm = 0xFFFFFFFC → `out_control` = 0010, `out_rd2_or_imm` = 0xFFFFFFFC.
3. **Forwarding at capture and x0 exclusion**: `in_rs1` = 3, rs1 data = 7, `fwd_we` = 1, `fwd_rd` = 3, `fwd_data` = 99 → `out_rd1` = 99. Repeat with `fwd_rd` = 0 and `in_rs1` = 0 → `out_rd1` = 7.
4. **Stall with forwarding while held**: capture, hold `out_ready` = 0 for 3 cycles → `in_ready` = 0 and outputs stable. Write-back to the held rs2 during the stall → `out_store_data` updates to `fwd_data`. Then `out_ready` = 1 → drains, or refills if `in_valid` = 1.
5. **Flush**: FULL with `in_valid` = 1 and `flush` = 1 → next cycle `out_valid` = 0 and the input is not presented.
6. **Illegal decode and reset**: ALUOp 11 or funct3 001 → `out_control` = 1111, `out_illegal` = 1. `rst_n` low mid-stall → all outputs 0 immediately, `in_ready` = 1.
